// File: rtl/bft_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bft_pkg
//  Description : Shared definitions for the BFT client injection arbiter:
//                packet field offsets, packet width helper, FSM encodings.
//                Packet word, MSB..LSB: {v, defl, addr, data}.
//  Revision    : 1.0 - initial release
// ============================================================================
package bft_pkg;

    // Arbitration states: normal bounce-priority and one-cycle forced client grant
    typedef enum logic [0:0] {
        ARB_BOUNCE = 1'b0,
        ARB_FORCE  = 1'b1
    } arb_state_e;

    // Total packet width including valid and deflection flags
    function automatic int pkt_w(input int a_w, input int d_w);
        return a_w + d_w + 2;
    endfunction

    // Valid flag position
    function automatic int v_bit(input int a_w, input int d_w);
        return a_w + d_w + 1;
    endfunction

    // Deflection flag position
    function automatic int defl_bit(input int a_w, input int d_w);
        return a_w + d_w;
    endfunction

    // Address field upper bit
    function automatic int addr_hi(input int a_w, input int d_w);
        return a_w + d_w - 1;
    endfunction

    // Address field lower bit (data occupies the bits below)
    function automatic int addr_lo(input int d_w);
        return d_w;
    endfunction

endpackage : bft_pkg
`default_nettype wire

// File: rtl/bft_sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : bft_sync_fifo
//  Description : Single-clock FIFO with first-word fall-through output.
//                Push on full and pop on empty are ignored; simultaneous
//                push and pop leave the occupancy unchanged.
//  Revision    : 1.0 - initial release
// ============================================================================
module bft_sync_fifo #(
    parameter int W     = 35,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             din,
    output logic [W-1:0]             dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] C_FULL = CW'(DEPTH);

    logic [W-1:0]  mem_q [0:DEPTH-1];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q,  count_d;
    logic          push_ok;
    logic          pop_ok;

    assign full  = (count_q == C_FULL);
    assign empty = (count_q == '0);
    assign count = count_q;
    assign dout  = mem_q[rd_ptr_q];

    // Pointer and occupancy update; pointers wrap naturally (DEPTH is a power of 2)
    always_comb begin
        push_ok  = push & ~full;
        pop_ok   = pop & ~empty;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Control state register; reset flushes the FIFO
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are don't-care until written
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

endmodule : bft_sync_fifo
`default_nettype wire

// File: rtl/bft_client_inject_arb.sv
`default_nettype none
// ============================================================================
//  Module      : bft_client_inject_arb
//  Description : Client-side injection arbiter at one BFT leaf port. Ejects
//                packets addressed to this client, captures misrouted
//                arrivals into a bounce FIFO and re-injects them, and shares
//                the injection slot with client traffic. Bounce traffic has
//                priority, but after STARVE_MAX consecutive bounce grants
//                with a waiting client one client grant is forced.
//  Options     : BFT_INJ_STATS_EN adds 32-bit injected/ejected/bounce counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module bft_client_inject_arb
    import bft_pkg::*;
#(
    parameter int N          = 4,
    parameter int A_W        = $clog2(N) + 1,
    parameter int D_W        = 32,
    parameter int POSX       = 0,
    parameter int DEPTH      = 4,
    parameter int STARVE_MAX = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ce,
    input  logic                 c_i_v,
    input  logic [A_W-1:0]       c_i_addr,
    input  logic [D_W-1:0]       c_i_d,
    output logic                 c_i_rdy,
    output logic                 c_o_v,
    output logic [D_W-1:0]       c_o_d,
    input  logic [A_W+D_W+1:0]   net_i,
    output logic [A_W+D_W+1:0]   net_o,
    output logic                 ovf,
    output logic                 done
`ifdef BFT_INJ_STATS_EN
    ,
    output logic [31:0]          st_inj,
    output logic [31:0]          st_ej,
    output logic [31:0]          st_bnc
`endif
);

    localparam int PW       = pkt_w(A_W, D_W);
    localparam int V_BIT    = v_bit(A_W, D_W);
    localparam int DEFL_BIT = defl_bit(A_W, D_W);
    localparam int ADDR_HI  = addr_hi(A_W, D_W);
    localparam int ADDR_LO  = addr_lo(D_W);
    localparam int FW       = A_W + D_W;
    localparam int CW       = $clog2(DEPTH) + 1;
    localparam int SW       = $clog2(STARVE_MAX + 1);

    localparam logic [A_W-1:0] C_POSX      = A_W'(POSX);
    localparam logic [CW-1:0]  C_BNC_GUARD = CW'(DEPTH - 2);
    localparam logic [SW-1:0]  C_STARVE    = SW'(STARVE_MAX);

    // Client count only sizes the address field
    localparam int unused_n = N;

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    arb_state_e     state_q,  state_d;
    logic [SW-1:0]  starve_q, starve_d;
    logic [PW-1:0]  net_o_q,  net_o_d;
    logic           c_o_v_q,  c_o_v_d;
    logic [D_W-1:0] c_o_d_q,  c_o_d_d;
    logic           ovf_q,    ovf_d;
    logic           done_q,   done_d;

    // ------------------------------------------------------------------------
    // FIFO interfaces
    // ------------------------------------------------------------------------
    logic           cli_push, cli_pop, cli_full, cli_empty;
    logic [FW-1:0]  cli_dout;
    logic [CW-1:0]  cli_count;
    logic           bnc_push, bnc_pop, bnc_full, bnc_empty;
    logic [FW-1:0]  bnc_dout;
    logic [CW-1:0]  bnc_count;

    logic           net_v;
    logic           addr_hit;
    logic           eject;
    logic           misroute;
    logic [SW-1:0]  starve_inc;
    logic           unused_sig;

    // Arriving deflection flag and client occupancy carry no decision weight here
    assign unused_sig = net_i[DEFL_BIT] ^ (^cli_count);

    assign net_v    = net_i[V_BIT];
    assign addr_hit = (net_i[ADDR_HI:ADDR_LO] == C_POSX);
    assign eject    = net_v & addr_hit;
    assign misroute = net_v & ~addr_hit;
    assign cli_push = c_i_v & ~cli_full;
    assign bnc_push = misroute & ~bnc_full;

    bft_sync_fifo #(
        .W     (FW),
        .DEPTH (DEPTH)
    ) u_cli_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (cli_push),
        .pop   (cli_pop),
        .din   ({c_i_addr, c_i_d}),
        .dout  (cli_dout),
        .full  (cli_full),
        .empty (cli_empty),
        .count (cli_count)
    );

    bft_sync_fifo #(
        .W     (FW),
        .DEPTH (DEPTH)
    ) u_bnc_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (bnc_push),
        .pop   (bnc_pop),
        .din   (net_i[ADDR_HI:0]),
        .dout  (bnc_dout),
        .full  (bnc_full),
        .empty (bnc_empty),
        .count (bnc_count)
    );

    // Ejection, overflow flag, idle detection and arbitration next-state
    always_comb begin
        state_d    = state_q;
        starve_d   = starve_q;
        bnc_pop    = 1'b0;
        cli_pop    = 1'b0;
        net_o_d    = '0;
        starve_inc = (starve_q == C_STARVE) ? C_STARVE : (starve_q + SW'(1));

        c_o_v_d = eject;
        c_o_d_d = eject ? net_i[D_W-1:0] : c_o_d_q;
        ovf_d   = ovf_q | (misroute & bnc_full);
        done_d  = bnc_empty & cli_empty & ~net_v & ~c_i_v;

        if (ce) begin
            case (state_q)
                ARB_BOUNCE: begin
                    if (!bnc_empty) begin
                        bnc_pop = 1'b1;
                        if (!cli_empty) begin
                            starve_d = starve_inc;
                            // Forced grant only when the bounce FIFO can absorb one more arrival
                            if ((starve_inc == C_STARVE) && (bnc_count <= C_BNC_GUARD)) begin
                                state_d = ARB_FORCE;
                            end
                        end
                    end else if (!cli_empty) begin
                        cli_pop  = 1'b1;
                        starve_d = '0;
                    end
                end
                ARB_FORCE: begin
                    cli_pop  = ~cli_empty;
                    starve_d = '0;
                    state_d  = ARB_BOUNCE;
                end
                default: begin
                    state_d = ARB_BOUNCE;
                end
            endcase
        end

        if (bnc_pop) begin
            net_o_d = {1'b1, 1'b1, bnc_dout};
        end else if (cli_pop) begin
            net_o_d = {1'b1, 1'b0, cli_dout};
        end
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ARB_BOUNCE;
            starve_q <= '0;
            net_o_q  <= '0;
            c_o_v_q  <= 1'b0;
            c_o_d_q  <= '0;
            ovf_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
            net_o_q  <= net_o_d;
            c_o_v_q  <= c_o_v_d;
            c_o_d_q  <= c_o_d_d;
            ovf_q    <= ovf_d;
            done_q   <= done_d;
        end
    end

    assign c_i_rdy = ~cli_full;
    assign c_o_v   = c_o_v_q;
    assign c_o_d   = c_o_d_q;
    assign net_o   = net_o_q;
    assign ovf     = ovf_q;
    assign done    = done_q;

`ifdef BFT_INJ_STATS_EN
    logic [31:0] st_inj_q, st_inj_d;
    logic [31:0] st_ej_q,  st_ej_d;
    logic [31:0] st_bnc_q, st_bnc_d;

    // Free-running event counters, wrapping modulo 2^32
    always_comb begin
        st_inj_d = st_inj_q + {31'd0, net_o_d[V_BIT]};
        st_ej_d  = st_ej_q  + {31'd0, eject};
        st_bnc_d = st_bnc_q + {31'd0, bnc_push};
    end

    // Counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            st_inj_q <= '0;
            st_ej_q  <= '0;
            st_bnc_q <= '0;
        end else begin
            st_inj_q <= st_inj_d;
            st_ej_q  <= st_ej_d;
            st_bnc_q <= st_bnc_d;
        end
    end

    assign st_inj = st_inj_q;
    assign st_ej  = st_ej_q;
    assign st_bnc = st_bnc_q;
`endif

endmodule : bft_client_inject_arb
`default_nettype wire

// File: tb/tb_bft_client_inject_arb.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bft_client_inject_arb
//  Description : Scoreboard bench for bft_client_inject_arb with
//                N=4, A_W=3, D_W=32, POSX=2, DEPTH=4, STARVE_MAX=3.
//                Options: BFT_INJ_STATS_EN connects and checks the counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bft_client_inject_arb;

    localparam int A_W  = 3;
    localparam int D_W  = 32;
    localparam int PW   = A_W + D_W + 2;
    localparam int POSX = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic            ce;
    logic            c_i_v;
    logic [A_W-1:0]  c_i_addr;
    logic [D_W-1:0]  c_i_d;
    logic            c_i_rdy;
    logic            c_o_v;
    logic [D_W-1:0]  c_o_d;
    logic [PW-1:0]   net_i;
    logic [PW-1:0]   net_o;
    logic            ovf;
    logic            done;
`ifdef BFT_INJ_STATS_EN
    logic [31:0]     st_inj, st_ej, st_bnc;
`endif

    int n_cmp = 0;
    int n_err = 0;
    int inj_cnt = 0;

    logic [PW-1:0]   bq[$];
    logic [PW-1:0]   cq[$];
    logic [D_W-1:0]  ej_q[$];
    bit              inj_log[$];
    logic [PW-1:0]   mon_exp;

    bft_client_inject_arb #(
        .N          (4),
        .A_W        (A_W),
        .D_W        (D_W),
        .POSX       (POSX),
        .DEPTH      (4),
        .STARVE_MAX (3)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .ce       (ce),
        .c_i_v    (c_i_v),
        .c_i_addr (c_i_addr),
        .c_i_d    (c_i_d),
        .c_i_rdy  (c_i_rdy),
        .c_o_v    (c_o_v),
        .c_o_d    (c_o_d),
        .net_i    (net_i),
        .net_o    (net_o),
        .ovf      (ovf),
        .done     (done)
`ifdef BFT_INJ_STATS_EN
        ,
        .st_inj   (st_inj),
        .st_ej    (st_ej),
        .st_bnc   (st_bnc)
`endif
    );

    always #5 clk = ~clk;

    // Output monitor: every injected word and ejected datum is matched
    // against the per-source expectation queues.
    always @(negedge clk) begin
        if (net_o[PW-1] === 1'b1) begin
            inj_log.push_back(net_o[PW-2]);
            inj_cnt++;
            n_cmp++;
            if (net_o[PW-2] === 1'b1 && bq.size() == 0) begin
                n_err++;
                $display("FAIL inj_unexpected_bounce got=%h required=none", net_o);
            end else if (net_o[PW-2] !== 1'b1 && cq.size() == 0) begin
                n_err++;
                $display("FAIL inj_unexpected_client got=%h required=none", net_o);
            end else begin
                if (net_o[PW-2] === 1'b1) mon_exp = bq.pop_front();
                else                      mon_exp = cq.pop_front();
                if (net_o !== mon_exp) begin
                    n_err++;
                    $display("FAIL inj_word got=%h required=%h", net_o, mon_exp);
                end
            end
        end else if (net_o !== '0) begin
            n_cmp++;
            n_err++;
            $display("FAIL idle_net_o got=%h required=0", net_o);
        end
        if (c_o_v === 1'b1) begin
            n_cmp++;
            if (ej_q.size() == 0) begin
                n_err++;
                $display("FAIL eject_unexpected got=%h required=none", c_o_d);
            end else begin
                mon_exp[D_W-1:0] = ej_q.pop_front();
                if (c_o_d !== mon_exp[D_W-1:0]) begin
                    n_err++;
                    $display("FAIL eject_data got=%h required=%h", c_o_d, mon_exp[D_W-1:0]);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic client_send(input logic [A_W-1:0] a, input logic [D_W-1:0] d);
        bit acc;
        acc = 1'b0;
        c_i_v = 1'b1; c_i_addr = a; c_i_d = d;
        for (int n = 0; n < 100 && !acc; n++) begin
            @(negedge clk);
            acc = c_i_rdy;
            tick();
        end
        c_i_v = 1'b0;
        if (acc) begin
            cq.push_back({1'b1, 1'b0, a, d});
        end else begin
            n_cmp++; n_err++;
            $display("FAIL client_send_timeout got=no_accept required=accept");
        end
    endtask

    task automatic net_drive(input logic [A_W-1:0] a, input logic [D_W-1:0] d, input bit expect_capture);
        net_i = {1'b1, 1'b1, a, d};
        if (a == A_W'(POSX))  ej_q.push_back(d);
        else if (expect_capture) bq.push_back({1'b1, 1'b1, a, d});
        tick();
        net_i = '0;
    endtask

    task automatic wait_inj(input int n);
        for (int k = 0; k < 200 && inj_log.size() < n; k++) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic drain();
        for (int k = 0; k < 300 && (bq.size() + cq.size() + ej_q.size()) != 0; k++) tick();
        repeat (3) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1; ce = 1'b0; c_i_v = 1'b0; c_i_addr = '0; c_i_d = '0; net_i = '0;
        repeat (2) tick();
        @(negedge clk);
        n_cmp++; if (net_o !== '0)   begin n_err++; $display("FAIL rst_net_o got=%h required=0", net_o); end
        n_cmp++; if (c_o_v !== 1'b0) begin n_err++; $display("FAIL rst_c_o_v got=%b required=0", c_o_v); end
        n_cmp++; if (c_o_d !== '0)   begin n_err++; $display("FAIL rst_c_o_d got=%h required=0", c_o_d); end
        n_cmp++; if (ovf !== 1'b0)   begin n_err++; $display("FAIL rst_ovf got=%b required=0", ovf); end
        n_cmp++; if (done !== 1'b0)  begin n_err++; $display("FAIL rst_done got=%b required=0", done); end
        n_cmp++; if (c_i_rdy !== 1'b1) begin n_err++; $display("FAIL rst_rdy got=%b required=1", c_i_rdy); end
        tick();
        rst = 1'b0;
    endtask

    task automatic test_client_path();
        ce = 1'b1;
        repeat (2) tick();
        @(negedge clk);
        n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL idle_done got=%b required=1", done); end
        tick();
        client_send(3'd1, 32'hA5);
        @(negedge clk);
        n_cmp++; if (done !== 1'b0)  begin n_err++; $display("FAIL send_done got=%b required=0", done); end
        n_cmp++; if (net_o !== '0)   begin n_err++; $display("FAIL early_net_o got=%h required=0", net_o); end
        @(negedge clk);
        n_cmp++; if (net_o !== {1'b1, 1'b0, 3'd1, 32'hA5}) begin
            n_err++; $display("FAIL client_latency got=%h required=%h", net_o, {1'b1, 1'b0, 3'd1, 32'hA5});
        end
        @(negedge clk);
        n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL done_after got=%b required=1", done); end
        drain();
    endtask

    task automatic test_eject();
        net_drive(3'(POSX), 32'h55, 1'b1);
        @(negedge clk);
        n_cmp++; if (c_o_v !== 1'b1 || c_o_d !== 32'h55) begin
            n_err++; $display("FAIL eject got=%b/%h required=1/00000055", c_o_v, c_o_d);
        end
        n_cmp++; if (net_o !== '0) begin n_err++; $display("FAIL eject_net_o got=%h required=0", net_o); end
        @(negedge clk);
        n_cmp++; if (c_o_v !== 1'b0) begin n_err++; $display("FAIL eject_pulse got=%b required=0", c_o_v); end
        drain();
    endtask

    task automatic test_bounce_first();
        ce = 1'b0;
        client_send(3'd3, 32'h11);
        net_drive(3'd0, 32'h77, 1'b1);
        inj_log.delete();
        ce = 1'b1;
        wait_inj(2);
        n_cmp++;
        if (inj_log.size() < 2 || inj_log[0] !== 1'b1 || inj_log[1] !== 1'b0) begin
            n_err++; $display("FAIL bounce_first got_n=%0d required=defl 1 then 0", inj_log.size());
        end
        drain();
        n_cmp++; if (bq.size() + cq.size() != 0) begin n_err++; $display("FAIL bounce_first_drain got=%0d required=0", bq.size() + cq.size()); end
    endtask

    task automatic test_starvation();
        logic [7:0] got;
        got = '0;
        ce = 1'b0;
        client_send(3'd3, 32'hC0);
        client_send(3'd3, 32'hC1);
        net_drive(3'd1, 32'hB00, 1'b1);
        inj_log.delete();
        ce = 1'b1;
        for (int i = 0; i < 11; i++) net_drive(3'(i % 2), 32'hB01 + 32'(i), 1'b1);
        wait_inj(8);
        for (int i = 0; i < 8 && i < inj_log.size(); i++) got[i] = inj_log[i];
        // Bounce, bounce, bounce, forced client: repeated twice (bit i = injection i)
        n_cmp++; if (got !== 8'b0111_0111) begin n_err++; $display("FAIL starve_pattern got=%b required=01110111", got); end
        n_cmp++; if (ovf !== 1'b0) begin n_err++; $display("FAIL starve_ovf got=%b required=0", ovf); end
        drain();
        n_cmp++; if (bq.size() + cq.size() != 0) begin n_err++; $display("FAIL starve_drain got=%0d required=0", bq.size() + cq.size()); end
    endtask

    task automatic test_backpressure();
        ce = 1'b0;
        for (int i = 0; i < 4; i++) client_send(3'(i), 32'hD0 + 32'(i));
        @(negedge clk);
        n_cmp++; if (c_i_rdy !== 1'b0) begin n_err++; $display("FAIL full_rdy got=%b required=0", c_i_rdy); end
        inj_log.delete();
        ce = 1'b1;
        wait_inj(4);
        n_cmp++; if (inj_log.size() != 4) begin n_err++; $display("FAIL bp_inj_count got=%0d required=4", inj_log.size()); end
        n_cmp++; if (c_i_rdy !== 1'b1) begin n_err++; $display("FAIL bp_rdy_after got=%b required=1", c_i_rdy); end
        drain();
        n_cmp++; if (cq.size() != 0) begin n_err++; $display("FAIL bp_drain got=%0d required=0", cq.size()); end
    endtask

    task automatic test_overflow();
        ce = 1'b0;
        for (int i = 0; i < 4; i++) net_drive(3'd3, 32'hE0 + 32'(i), 1'b1);
        @(negedge clk);
        n_cmp++; if (ovf !== 1'b0) begin n_err++; $display("FAIL ovf_early got=%b required=0", ovf); end
        net_drive(3'd3, 32'hEF, 1'b0);
        @(negedge clk);
        n_cmp++; if (ovf !== 1'b1) begin n_err++; $display("FAIL ovf_set got=%b required=1", ovf); end
        ce = 1'b1;
        drain();
        n_cmp++; if (ovf !== 1'b1) begin n_err++; $display("FAIL ovf_sticky got=%b required=1", ovf); end
        n_cmp++; if (bq.size() != 0) begin n_err++; $display("FAIL ovf_drain got=%0d required=0", bq.size()); end
    endtask

    task automatic test_reset_mid();
        int snap;
        ce = 1'b0;
        client_send(3'd0, 32'hF0);
        client_send(3'd1, 32'hF1);
        net_drive(3'd0, 32'hF2, 1'b1);
        net_drive(3'd1, 32'hF3, 1'b1);
        rst = 1'b1; ce = 1'b1;
        net_i = {1'b1, 1'b1, 3'(POSX), 32'h99};
        tick();
        net_i = '0;
        tick();
        bq.delete(); cq.delete(); ej_q.delete();
        @(negedge clk);
        n_cmp++; if (net_o !== '0)     begin n_err++; $display("FAIL mid_rst_net_o got=%h required=0", net_o); end
        n_cmp++; if (c_o_v !== 1'b0)   begin n_err++; $display("FAIL mid_rst_c_o_v got=%b required=0", c_o_v); end
        n_cmp++; if (c_i_rdy !== 1'b1) begin n_err++; $display("FAIL mid_rst_rdy got=%b required=1", c_i_rdy); end
        n_cmp++; if (ovf !== 1'b0)     begin n_err++; $display("FAIL mid_rst_ovf got=%b required=0", ovf); end
`ifdef BFT_INJ_STATS_EN
        n_cmp++; if ({st_inj, st_ej, st_bnc} !== '0) begin
            n_err++; $display("FAIL mid_rst_stats got=%h/%h/%h required=0", st_inj, st_ej, st_bnc);
        end
`endif
        tick();
        rst = 1'b0;
        snap = inj_cnt;
        repeat (10) tick();
        n_cmp++; if (inj_cnt != snap) begin n_err++; $display("FAIL stale_after_rst got=%0d required=0", inj_cnt - snap); end
        n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL idle_after_rst got=%b required=1", done); end
    endtask

    initial begin
        test_reset();
        test_client_path();
        test_eject();
        test_bounce_first();
        test_starvation();
        test_backpressure();
        test_overflow();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_bft_client_inject_arb
`default_nettype wire
